// File: rtl/scsi_resp_pkg.sv
// scsi_resp_pkg: shared state encoding and constants for the SCSI DMA responder
package scsi_resp_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;
  localparam logic DIR_TO_MEM = 1'b0;
  localparam logic DIR_TO_SCSI = 1'b1;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/scsi_resp_fifo.sv
// scsi_resp_fifo: DEPTH x 8 synchronous byte FIFO with async clear
module scsi_resp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign head = mem[rd];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  // storage needs no reset; only pointers and occupancy define contents
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/scsi_dreq_responder.sv
// scsi_dreq_responder: SCSI-controller side of the SDMAC DMA request/ack handshake
module scsi_dreq_responder
  import scsi_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAIT_STATES = 1,
  parameter int TC_W = 16
) (
  input  logic            SCLK,
  input  logic            _RST,
  input  logic            DMADIR,
  input  logic            TC_LOAD,
  input  logic [TC_W-1:0] TC_VALUE,
  output logic            TC_ZERO,
  output logic            CDREQ_,
  input  logic            DACK_,
  input  logic            RE_,
  input  logic            WE_,
  input  logic [7:0]      PD_IN,
  output logic [7:0]      PD_OUT,
  output logic            PD_OE,
  output logic            CDSACK_,
  input  logic            SRC_VALID,
  input  logic [7:0]      SRC_DATA,
  output logic            SRC_READY,
  output logic            SNK_VALID,
  output logic [7:0]      SNK_DATA,
  input  logic            SNK_READY
);
  state_t state, state_nx;
  logic dir, dir_nx;
  logic [WAIT_W-1:0] wcnt, wcnt_nx;
  logic [TC_W-1:0] tc, tc_nx;
  logic cdreq_nx, cdsack_nx, pd_oe_nx, xfer;
  logic [7:0] pd_out_nx, head;
  logic full, empty;
  logic [$clog2(DEPTH):0] count;
  logic rq_dir, rq, hit, push, pop;
  assign rq_dir = state == IDLE ? DMADIR : dir;
  assign rq = tc != '0 && (rq_dir == DIR_TO_SCSI ? !full : count != '0);
  assign hit = !DACK_ && (dir == DIR_TO_SCSI ? !WE_ : !RE_);
  assign SRC_READY = !full && DMADIR == DIR_TO_MEM;
  assign SNK_VALID = !empty && DMADIR == DIR_TO_SCSI;
  assign SNK_DATA = head;
  assign TC_ZERO = tc == '0;
  assign push = (SRC_VALID && SRC_READY) || (xfer && dir == DIR_TO_SCSI);
  assign pop = (SNK_VALID && SNK_READY) || (xfer && dir == DIR_TO_MEM);
  assign tc_nx = TC_LOAD ? TC_VALUE : (xfer && tc != '0) ? tc - 1'b1 : tc;
  scsi_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(SCLK),
    .rst_n(_RST),
    .push(push),
    .pop(pop),
    .din(xfer && dir == DIR_TO_SCSI ? PD_IN : SRC_DATA),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // handshake sequencing; xfer marks the edge where the byte actually moves
  always_comb begin
    state_nx = state;
    dir_nx = dir;
    wcnt_nx = wcnt;
    cdreq_nx = CDREQ_;
    cdsack_nx = CDSACK_;
    pd_oe_nx = PD_OE;
    pd_out_nx = PD_OUT;
    xfer = 1'b0;
    case (state)
      IDLE: begin
        dir_nx = DMADIR;
        cdreq_nx = !rq;
        state_nx = rq ? REQ : IDLE;
      end
      REQ: begin
        if (!rq) begin
          cdreq_nx = 1'b1;
          state_nx = IDLE;
        end else if (hit) begin
          cdreq_nx = 1'b1;
          wcnt_nx = WAIT_W'(WAIT_STATES);
          state_nx = WAIT;
          pd_oe_nx = dir == DIR_TO_MEM;
          pd_out_nx = dir == DIR_TO_MEM ? head : PD_OUT;
        end
      end
      WAIT: begin
        if (!hit) begin
          pd_oe_nx = 1'b0;
          state_nx = IDLE;
        end else if (wcnt == '0) begin
          cdsack_nx = 1'b0;
          xfer = 1'b1;
          state_nx = ACK;
        end else begin
          wcnt_nx = wcnt - 1'b1;
        end
      end
      ACK: begin
        if (!hit) begin
          cdsack_nx = 1'b1;
          pd_oe_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and registered bus outputs; reset drops every handshake at once
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state <= IDLE;
      dir <= DIR_TO_MEM;
      wcnt <= '0;
      tc <= '0;
      CDREQ_ <= 1'b1;
      CDSACK_ <= 1'b1;
      PD_OE <= 1'b0;
      PD_OUT <= '0;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
      wcnt <= wcnt_nx;
      tc <= tc_nx;
      CDREQ_ <= cdreq_nx;
      CDSACK_ <= cdsack_nx;
      PD_OE <= pd_oe_nx;
      PD_OUT <= pd_out_nx;
    end
  end
endmodule
